framebuffer_arbiter: RTL and testbench
======================================

Name: framebuffer_arbiter

Overview:
- Shares one single-port, double-buffered framebuffer RAM between two requesters: the LED matrix scan controller (display reads) and the CPU (pixel writes).
- Display reads come from the front buffer. CPU writes go to the back buffer.
- Buffer swaps are applied only at frame boundaries, so a displayed frame never tears.
- Sits between the LED controller, the CPU store path and the framebuffer RAM.

Parameters:
- ROW_W, 5, row address width (32 scan rows)
- COL_W, 6, column address width (64 columns)
- DATA_W, 6, pixel word width (R1 G1 B1 R2 G2 B2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- disp_re  in  1  display read request; one read per cycle while high
- disp_row  in  ROW_W  display read row
- disp_col  in  COL_W  display read column
- disp_data  out  DATA_W  read data returned to the display
- disp_valid  out  1  disp_data valid
- frame_end  in  1  one-cycle pulse from the LED controller after the last row is latched
- cpu_wr_valid  in  1  CPU write request
- cpu_wr_ready  out  1  write accepted this cycle
- cpu_row  in  ROW_W  write row
- cpu_col  in  COL_W  write column
- cpu_data  in  DATA_W  write data
- swap_req  in  1  one-cycle pulse requesting a buffer swap
- swap_pending  out  1  a swap is queued
- swap_done  out  1  one-cycle pulse when the swap is applied
- front_sel  out  1  buffer currently displayed
- cpu_stall_cnt  out  16  saturating count of stalled write cycles
- ram_addr  out  1+ROW_W+COL_W  RAM address; layout {buffer, row, col}
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data; synchronous, 1-cycle latency

Behaviour:
- Reset (rst low, asynchronous) clears:
  - disp_valid, swap_pending, swap_done, front_sel, cpu_stall_cnt all to 0
  - the swap FSM returns to IDLE
  - disp_data is don't-care while disp_valid is 0
- RAM port and write handshake, all combinational from current inputs and state:
  - The display has absolute priority.
  - cpu_wr_ready = !disp_re.
  - When disp_re is high: ram_addr = {front_sel, disp_row, disp_col}, ram_we = 0.
  - Else, when cpu_wr_valid is high: ram_addr = {~front_sel, cpu_row, cpu_col}, ram_we = 1, ram_wdata = cpu_data.
  - Else: ram_we = 0, and ram_addr holds its last value. It is registered shadow; no spurious write occurs.
  - A write completes exactly on a cycle with cpu_wr_valid && cpu_wr_ready.
  - The CPU must hold row, col and data stable until that cycle.
- Read latency:
  - disp_valid is a register loaded with disp_re, so it is high exactly 1 cycle after each read request.
  - disp_data = ram_rdata.
  - Back-to-back reads give one valid word per cycle.
- Stall counter:
  - cpu_stall_cnt increments on every cycle with cpu_wr_valid && !cpu_wr_ready.
  - It saturates at 0xFFFF and clears only on reset.
- Swap FSM has three states: IDLE, PENDING, SWAP.
  - IDLE -> PENDING on swap_req.
  - IDLE -> SWAP when swap_req and frame_end occur in the same cycle.
  - PENDING -> SWAP on frame_end.
  - Further swap_req pulses while in PENDING or SWAP are absorbed, not queued.
  - SWAP lasts 1 cycle: front_sel toggles at the end of it, swap_done = 1 during it, then the FSM returns to IDLE.
  - swap_pending = 1 in PENDING and in SWAP.
  - frame_end in IDLE with no swap_req has no effect.
- Simultaneous events:
  - A write accepted in the SWAP cycle uses the pre-toggle back buffer (~front_sel before the toggle).
  - A display read in the SWAP cycle uses the pre-toggle front buffer.
  - The first access after the toggle uses the new selection.
- Address wrap-around is not applicable: the address is a direct concatenation with no arithmetic.

Test Plan:
- Reset, then idle:
  - rst low for 2 cycles, then high -> front_sel=0, disp_valid=0, swap_done=0, cpu_stall_cnt=0, ram_we=0.
- CPU write, then display read:
  - CPU write row=3 col=10 data=0x2A with disp_re=0 -> ram_we=1, ram_addr={1,3,10}, cpu_wr_ready=1.
  - Then swap_req followed by frame_end -> swap_done pulses once, front_sel=1.
  - Then display read of (3,10) -> ram_addr={1,3,10}, disp_valid high next cycle, disp_data=0x2A.
- Contention:
  - disp_re high for 64 consecutive cycles with cpu_wr_valid held high -> cpu_wr_ready=0 and no ram_we throughout.
  - cpu_stall_cnt = 64 at the end.
  - The write completes in the first cycle after disp_re falls.
- Swap timing:
  - swap_req at cycle 10, second swap_req at cycle 20, frame_end at cycle 50.
  - Required: swap_pending from cycle 11 onward, single swap_done at cycle 51, exactly one front_sel toggle.
- Simultaneous events:
  - swap_req and frame_end in the same cycle, together with an accepted CPU write -> immediate SWAP.
  - The write lands in the old back buffer; front_sel toggles once.
- Reset mid-operation:
  - Assert rst while in PENDING with front_sel=1 -> outputs clear immediately (asynchronous).
  - FSM returns to IDLE, front_sel=0, and no swap_done occurs after release.

Source files
------------

// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter
//   Shares one single-port, double-buffered framebuffer RAM between the LED
//   scan controller (reads from the front buffer) and the CPU (writes to the
//   back buffer). Buffer swaps are deferred to frame boundaries so a displayed
//   frame never tears.
//
// Ports
//   clk_i, rst_ni                      clock, async active-low reset
//   disp_re_i/disp_row_i/disp_col_i    display read request and address
//   disp_data_o/disp_valid_o           read data, valid one cycle after request
//   frame_end_i                        pulse after the last row is latched
//   cpu_wr_valid_i/cpu_wr_ready_o      CPU write handshake
//   cpu_row_i/cpu_col_i/cpu_data_i     CPU write address and data
//   swap_req_i                         pulse requesting a buffer swap
//   swap_pending_o/swap_done_o         swap queued / swap applied this cycle
//   front_sel_o                        buffer currently displayed
//   cpu_stall_cnt_o                    saturating count of stalled write cycles
//   ram_addr_o/ram_we_o/ram_wdata_o    RAM port, address = {buffer, row, col}
//   ram_rdata_i                        RAM read data, 1-cycle latency
//
// Swap FSM
//   state   | meaning
//   IDLE    | no swap requested
//   PENDING | swap requested, waiting for frame_end
//   SWAP    | swap applied this cycle; front_sel toggles at its end
module framebuffer_arbiter #(
    parameter int ROW_W  = 5,
    parameter int COL_W  = 6,
    parameter int DATA_W = 6
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     disp_re_i,
    input  logic [ROW_W-1:0]         disp_row_i,
    input  logic [COL_W-1:0]         disp_col_i,
    output logic [DATA_W-1:0]        disp_data_o,
    output logic                     disp_valid_o,
    input  logic                     frame_end_i,
    input  logic                     cpu_wr_valid_i,
    output logic                     cpu_wr_ready_o,
    input  logic [ROW_W-1:0]         cpu_row_i,
    input  logic [COL_W-1:0]         cpu_col_i,
    input  logic [DATA_W-1:0]        cpu_data_i,
    input  logic                     swap_req_i,
    output logic                     swap_pending_o,
    output logic                     swap_done_o,
    output logic                     front_sel_o,
    output logic [15:0]              cpu_stall_cnt_o,
    output logic [ROW_W+COL_W:0]     ram_addr_o,
    output logic                     ram_we_o,
    output logic [DATA_W-1:0]        ram_wdata_o,
    input  logic [DATA_W-1:0]        ram_rdata_i
);

    localparam int ADDR_W = 1 + ROW_W + COL_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SWAP    = 2'd2
    } swap_state_t;

    swap_state_t       state_q;
    logic              swap_pending_q;
    logic              swap_done_q;
    logic              front_sel_q;
    logic              disp_valid_q;
    logic [15:0]       stall_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              we_d;

    // Display always wins the port; an idle port keeps the last address so
    // the RAM address bus does not toggle needlessly.
    always_comb begin
        addr_d = addr_q;
        we_d   = 1'b0;
        if (disp_re_i) begin
            addr_d = {front_sel_q, disp_row_i, disp_col_i};
        end else if (cpu_wr_valid_i) begin
            addr_d = {~front_sel_q, cpu_row_i, cpu_col_i};
            we_d   = 1'b1;
        end
    end

    assign ram_addr_o      = addr_d;
    assign ram_we_o        = we_d;
    assign ram_wdata_o     = cpu_data_i;
    assign cpu_wr_ready_o  = ~disp_re_i;
    assign disp_data_o     = ram_rdata_i;
    assign disp_valid_o    = disp_valid_q;
    assign cpu_stall_cnt_o = stall_cnt_q;
    assign swap_pending_o  = swap_pending_q;
    assign swap_done_o     = swap_done_q;
    assign front_sel_o     = front_sel_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q       <= '0;
            disp_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            addr_q       <= addr_d;
            disp_valid_q <= disp_re_i;
            if (cpu_wr_valid_i && disp_re_i && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    // Outputs are registered alongside the state so swap_done/swap_pending
    // are glitch-free. Extra swap_req pulses in PENDING/SWAP are absorbed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
            front_sel_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (swap_req_i && frame_end_i) begin
                        state_q        <= SWAP;
                        swap_pending_q <= 1'b1;
                        swap_done_q    <= 1'b1;
                    end else if (swap_req_i) begin
                        state_q        <= PENDING;
                        swap_pending_q <= 1'b1;
                    end
                end
                PENDING: begin
                    if (frame_end_i) begin
                        state_q     <= SWAP;
                        swap_done_q <= 1'b1;
                    end
                end
                SWAP: begin
                    state_q        <= IDLE;
                    swap_pending_q <= 1'b0;
                    swap_done_q    <= 1'b0;
                    front_sel_q    <= ~front_sel_q;
                end
                default: begin
                    state_q        <= IDLE;
                    swap_pending_q <= 1'b0;
                    swap_done_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
module tb_framebuffer_arbiter;

    localparam int ROW_W  = 5;
    localparam int COL_W  = 6;
    localparam int DATA_W = 6;
    localparam int ADDR_W = 1 + ROW_W + COL_W;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              disp_re_i;
    logic [ROW_W-1:0]  disp_row_i;
    logic [COL_W-1:0]  disp_col_i;
    logic [DATA_W-1:0] disp_data_o;
    logic              disp_valid_o;
    logic              frame_end_i;
    logic              cpu_wr_valid_i;
    logic              cpu_wr_ready_o;
    logic [ROW_W-1:0]  cpu_row_i;
    logic [COL_W-1:0]  cpu_col_i;
    logic [DATA_W-1:0] cpu_data_i;
    logic              swap_req_i;
    logic              swap_pending_o;
    logic              swap_done_o;
    logic              front_sel_o;
    logic [15:0]       cpu_stall_cnt_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic              ram_we_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [DATA_W-1:0] ram_rdata_i;

    framebuffer_arbiter #(.ROW_W(ROW_W), .COL_W(COL_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .disp_re_i(disp_re_i), .disp_row_i(disp_row_i), .disp_col_i(disp_col_i),
        .disp_data_o(disp_data_o), .disp_valid_o(disp_valid_o),
        .frame_end_i(frame_end_i),
        .cpu_wr_valid_i(cpu_wr_valid_i), .cpu_wr_ready_o(cpu_wr_ready_o),
        .cpu_row_i(cpu_row_i), .cpu_col_i(cpu_col_i), .cpu_data_i(cpu_data_i),
        .swap_req_i(swap_req_i), .swap_pending_o(swap_pending_o),
        .swap_done_o(swap_done_o), .front_sel_o(front_sel_o),
        .cpu_stall_cnt_o(cpu_stall_cnt_o),
        .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Physical RAM driven by the DUT's port
    logic [DATA_W-1:0] ram_mem [0:(1<<ADDR_W)-1];
    always @(posedge clk_i) begin
        if (ram_we_o) ram_mem[ram_addr_o] <= ram_wdata_o;
        ram_rdata_i <= ram_mem[ram_addr_o];
    end

    // Reference model: framebuffer contents and swap bookkeeping per the rules
    logic [DATA_W-1:0] fb [0:1][0:(1<<ROW_W)-1][0:(1<<COL_W)-1];
    int unsigned       m_front;
    bit                m_queued;    // swap requested, waiting for a frame end
    bit                m_swap_now;  // swap being applied this cycle
    int unsigned       m_stall;
    logic [ADDR_W-1:0] m_last_addr;
    bit                m_rd_valid;
    logic [DATA_W-1:0] m_rd_data;

    int n_vec = 0;
    int n_err = 0;
    int n_done_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_front     = 0;
        m_queued    = 0;
        m_swap_now  = 0;
        m_stall     = 0;
        m_last_addr = '0;
        m_rd_valid  = 0;
    endtask

    task automatic idle_inputs();
        disp_re_i      = 1'b0;
        cpu_wr_valid_i = 1'b0;
        swap_req_i     = 1'b0;
        frame_end_i    = 1'b0;
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic step();
        logic              exp_we;
        logic [ADDR_W-1:0] exp_addr;
        bit                rd;
        logic [DATA_W-1:0] rd_val;
        #1;
        exp_we   = !disp_re_i && cpu_wr_valid_i;
        exp_addr = m_last_addr;
        if (disp_re_i)           exp_addr = {m_front[0], disp_row_i, disp_col_i};
        else if (cpu_wr_valid_i) exp_addr = {~m_front[0], cpu_row_i, cpu_col_i};
        chk("cpu_wr_ready", cpu_wr_ready_o, !disp_re_i);
        chk("ram_we", ram_we_o, exp_we);
        chk("ram_addr", ram_addr_o, exp_addr);
        if (exp_we) chk("ram_wdata", ram_wdata_o, cpu_data_i);

        rd     = disp_re_i;
        rd_val = fb[m_front][disp_row_i][disp_col_i];
        if (exp_we) fb[~m_front[0]][cpu_row_i][cpu_col_i] = cpu_data_i;
        if (disp_re_i || cpu_wr_valid_i) m_last_addr = exp_addr;
        if (cpu_wr_valid_i && disp_re_i && m_stall < 16'hFFFF) m_stall++;
        if (m_swap_now) begin
            m_front    = m_front ^ 1;
            m_swap_now = 0;
        end else if (m_queued) begin
            if (frame_end_i) begin
                m_queued   = 0;
                m_swap_now = 1;
            end
        end else if (swap_req_i) begin
            if (frame_end_i) m_swap_now = 1;
            else             m_queued   = 1;
        end
        m_rd_valid = rd;
        m_rd_data  = rd_val;

        @(posedge clk_i);
        #1;
        chk("disp_valid", disp_valid_o, m_rd_valid);
        if (m_rd_valid) chk("disp_data", disp_data_o, m_rd_data);
        chk("swap_pending", swap_pending_o, m_queued || m_swap_now);
        chk("swap_done", swap_done_o, m_swap_now);
        chk("front_sel", front_sel_o, m_front);
        chk("stall_cnt", cpu_stall_cnt_o, m_stall);
        if (swap_done_o) n_done_seen++;
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        #1;
        chk("rst_disp_valid", disp_valid_o, 0);
        chk("rst_swap_pending", swap_pending_o, 0);
        chk("rst_swap_done", swap_done_o, 0);
        chk("rst_front_sel", front_sel_o, 0);
        chk("rst_stall_cnt", cpu_stall_cnt_o, 0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
    endtask

    task automatic cpu_write(input int r, input int c, input int d);
        cpu_wr_valid_i = 1'b1;
        cpu_row_i      = ROW_W'(r);
        cpu_col_i      = COL_W'(c);
        cpu_data_i     = DATA_W'(d);
    endtask

    initial begin
        int          front_before;
        int          done_before;
        logic [ADDR_W-1:0] a;

        for (int i = 0; i < (1 << ADDR_W); i++) ram_mem[i] = '0;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < (1 << ROW_W); r++)
                for (int c = 0; c < (1 << COL_W); c++) fb[b][r][c] = '0;
        disp_row_i = '0; disp_col_i = '0;
        cpu_row_i = '0; cpu_col_i = '0; cpu_data_i = '0;
        idle_inputs();
        rst_ni = 1'b0;
        @(negedge clk_i);

        // Reset, then idle
        do_reset();
        step();

        // CPU write lands in the back buffer (1,3,10)
        cpu_write(3, 10, 'h2A);
        #1;
        a = {1'b1, 5'd3, 6'd10};
        chk("wr_addr_direct", ram_addr_o, a);
        step();
        cpu_wr_valid_i = 1'b0;

        // Swap at the next frame end
        swap_req_i = 1'b1; step(); swap_req_i = 1'b0;
        step(); step();
        done_before = n_done_seen;
        frame_end_i = 1'b1; step(); frame_end_i = 1'b0;
        step(); step();
        chk("swap1_done_count", n_done_seen - done_before, 1);
        chk("swap1_front", front_sel_o, 1);

        // Display read of (3,10) now returns 0x2A from buffer 1
        disp_re_i = 1'b1; disp_row_i = 5'd3; disp_col_i = 6'd10;
        step();
        chk("read_back_data", disp_data_o, 'h2A);
        disp_re_i = 1'b0;
        step();

        // Contention: 64 display reads with a write held pending
        do_reset();
        cpu_write(9, 20, 'h11);
        for (int i = 0; i < 64; i++) begin
            disp_re_i  = 1'b1;
            disp_row_i = ROW_W'($urandom);
            disp_col_i = COL_W'($urandom);
            step();
        end
        chk("contention_stall", cpu_stall_cnt_o, 64);
        disp_re_i = 1'b0;
        step();
        cpu_wr_valid_i = 1'b0;
        chk("contention_written", fb[1][9][20], 'h11);

        // Swap timing: req at 10, second req at 20, frame_end at 50
        step();
        front_before = front_sel_o;
        done_before  = n_done_seen;
        for (int cyc = 10; cyc <= 55; cyc++) begin
            swap_req_i  = (cyc == 10 || cyc == 20);
            frame_end_i = (cyc == 50);
            step();
        end
        idle_inputs();
        chk("timing_done_count", n_done_seen - done_before, 1);
        chk("timing_front_toggle", front_sel_o, front_before ^ 1);

        // Simultaneous swap_req + frame_end + accepted write
        front_before = m_front;
        swap_req_i = 1'b1; frame_end_i = 1'b1;
        cpu_write(7, 5, 'h15);
        step();
        idle_inputs();
        chk("simul_old_back", fb[front_before ^ 1][7][5], 'h15);
        step();
        chk("simul_front", front_sel_o, front_before ^ 1);
        disp_re_i = 1'b1; disp_row_i = 5'd7; disp_col_i = 6'd5;
        step();
        chk("simul_read", disp_data_o, 'h15);
        idle_inputs();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            disp_re_i      = ($urandom_range(0, 1) == 1);
            disp_row_i     = ROW_W'($urandom_range(0, 3));
            disp_col_i     = COL_W'($urandom_range(0, 3));
            cpu_wr_valid_i = ($urandom_range(0, 2) != 0);
            cpu_row_i      = ROW_W'($urandom_range(0, 3));
            cpu_col_i      = COL_W'($urandom_range(0, 3));
            cpu_data_i     = DATA_W'($urandom);
            swap_req_i     = ($urandom_range(0, 15) == 0);
            frame_end_i    = ($urandom_range(0, 15) == 0);
            step();
        end
        idle_inputs();
        step(); step();

        // Reset mid-operation while PENDING with front_sel=1
        if (m_front == 0) begin
            swap_req_i = 1'b1; frame_end_i = 1'b1; step();
            idle_inputs(); step();
        end
        swap_req_i = 1'b1; step(); swap_req_i = 1'b0;
        step();
        chk("midrst_pre_front", front_sel_o, 1);
        chk("midrst_pre_pending", swap_pending_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("midrst_front", front_sel_o, 0);
        chk("midrst_pending", swap_pending_o, 0);
        chk("midrst_valid", disp_valid_o, 0);
        chk("midrst_stall", cpu_stall_cnt_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        done_before = n_done_seen;
        for (int i = 0; i < 6; i++) begin
            frame_end_i = (i == 2);
            step();
        end
        idle_inputs();
        chk("midrst_no_done", n_done_seen - done_before, 0);
        chk("midrst_front_after", front_sel_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
